load_store_unit: RTL
====================

Name: load_store_unit

Overview:
Memory-stage neighbour of the single-cycle RV32I datapath. Consumes ALUResult (address), WriteData (store data) and the decoded load/store controls, drives a word-wide request/acknowledge data bus with variable wait states, and returns the formatted ReadData to the result mux. While an access is in flight it holds the core via stall, which freezes the PC register and suppresses register-file write.

Parameters:
TIMEOUT_CYCLES, 255, maximum BUSY cycles without bus_ack before the access is aborted; legal range 1..65535.

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  synchronous reset, active-high
mem_read  input  1  current instruction is a load
mem_write  input  1  current instruction is a store
funct3  input  3  instr[14:12], access size/sign
addr  input  32  byte address (ALUResult)
wdata  input  32  store data (WriteData), LSB-aligned
read_data  output  32  formatted load result (ReadData)
stall  output  1  hold PC and suppress RegWrite this cycle
fault  output  1  sticky fault flag
fault_cause  output  2  01 misaligned, 10 illegal access, 11 bus timeout, 00 none
bus_req  output  1  bus request, registered
bus_we  output  1  1 = write
bus_addr  output  32  word address, {addr[31:2],2'b00}
bus_be  output  4  byte enables
bus_wdata  output  32  lane-replicated store data
bus_rdata  input  32  read word, valid with bus_ack
bus_ack  input  1  access complete, single-cycle pulse

Behaviour:
- Reset values: state IDLE, read_data 0, fault 0, fault_cause 00, bus_req 0, bus_we 0, bus_addr 0, bus_be 0, bus_wdata 0, timeout counter 0. stall is combinational and evaluates to 0 in IDLE with no access.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Access request = mem_read xor mem_write, legal funct3, aligned.
  - On request: stall=1, load bus_* registers, go BUSY.
  - Otherwise: stall=0.
- BUSY:
  - stall=1; bus_req=1; bus_we, bus_addr, bus_be and bus_wdata held stable until ack.
  - Counter increments each cycle.
  - On bus_ack: capture the formatted load into read_data (stores leave it unchanged), drop bus_req, go DONE.
- DONE:
  - stall=0 for exactly one cycle. The core retires the instruction at the end of this cycle, then the FSM returns to IDLE.
  - No new request is accepted in DONE, which prevents re-issue of the same instruction.
- Latency: ack on the first BUSY cycle gives 3 cycles per memory instruction (stall high 2 cycles). Each extra wait cycle adds 1.
- Load formatting by funct3 and byte offset o=addr[1:0]:
  - 000 LB: sign-extend byte o.
  - 100 LBU: zero-extend byte o.
  - 001 LH: sign-extend halfword addr[1].
  - 101 LHU: zero-extend halfword addr[1].
  - 010 LW: whole word.
- Store lanes:
  - SB: bus_be = 4'b0001<<o, bus_wdata = wdata[7:0] replicated 4x.
  - SH: bus_be = 4'b0011<<(2*addr[1]), bus_wdata = wdata[15:0] replicated 2x.
  - SW: bus_be = 4'b1111, bus_wdata = wdata.
- Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with o!=0):
  - No bus access, stall=0, read_data unchanged.
  - Sets fault; fault_cause=01.
- Illegal (mem_read&mem_write both high; load funct3 011/110/111; store funct3 other than 000/001/010):
  - No access, stall=0; fault_cause=10.
- Timeout: counter reaches TIMEOUT_CYCLES in BUSY without ack.
  - Drop bus_req, read_data=0 for loads, go DONE; fault_cause=11.
- fault is sticky until rst. fault_cause records only the first fault; later faults do not overwrite it.
- bus_ack outside BUSY is ignored. bus_rdata is sampled only with ack in BUSY.
- When bus_req=0: bus_we=0 and bus_be=0.
- rst in any state, including mid-BUSY, takes precedence:
  - Next edge: IDLE, bus_req=0, counter cleared.
  - A late ack after reset is ignored.

Test Plan:
- LW addr 0x0000_1004, ack 1 cycle after req rises, bus_rdata 0xDEAD_BEEF -> bus_addr 0x1004, bus_be 1111, stall high 2 cycles, DONE cycle read_data=0xDEADBEEF, total 3 cycles.
- SB addr 0x0000_2003, wdata 0x1234_56AB, ack after 3 wait cycles -> bus_we 1, bus_be 1000, bus_wdata 0xABABABAB held stable all BUSY cycles, stall high 5 cycles.
- LB addr 0x...01, bus_rdata 0x0000_8000 -> read_data 0xFFFFFF80; repeat as LBU -> 0x00000080; LH addr 0x...02, rdata 0x8001_0000 -> 0xFFFF8001.
- LW addr 0x0000_1002 -> bus_req never rises, stall 0, fault=1, fault_cause=01. A following SW addr 0x...01 leaves fault_cause at 01.
- TIMEOUT_CYCLES=4, LW with no ack -> bus_req high 4 cycles then low, read_data=0, fault_cause=11, stall low in DONE.
- rst pulsed on 2nd BUSY cycle, ack arrives the cycle after -> bus_req 0 after the reset edge, state IDLE, read_data 0, fault 0, ack ignored.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit for the single-cycle RV32I core: turns a decoded load/store
// into one request/acknowledge bus transaction, stalls the core while it is in
// flight and returns the sign/zero-extended load result.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Last BUSY cycle index before the access is abandoned (counter starts at 0).
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] CAUSE_MISALIGNED = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL    = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT    = 2'b11;

    state_t      state_q, state_d;
    logic [31:0] read_data_q, read_data_d;
    logic        fault_q, fault_d;
    logic [1:0]  fault_cause_q, fault_cause_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [15:0] cnt_q, cnt_d;
    // Access size/sign and byte offset kept for formatting the returned word.
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;

    logic        single_op;
    logic        f3_legal;
    logic        misaligned;
    logic        is_access;
    logic        is_illegal;
    logic        is_misaligned;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [7:0]  rd_byte [4];
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;

    // Byte lanes of the returned bus word.
    for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
        assign rd_byte[gi] = bus_rdata[8*gi +: 8];
    end

    // Classify the current instruction: legal access, illegal, or misaligned.
    always_comb begin
        single_op = mem_read ^ mem_write;
        f3_legal  = 1'b0;
        if (mem_read && !mem_write) begin
            case (funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
                default:                                f3_legal = 1'b0;
            endcase
        end else if (mem_write && !mem_read) begin
            case (funct3)
                3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
                default:                f3_legal = 1'b0;
            endcase
        end
        case (funct3[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        is_illegal    = (mem_read & mem_write) | (single_op & ~f3_legal);
        is_misaligned = single_op & f3_legal & misaligned;
        is_access     = single_op & f3_legal & ~misaligned;
    end

    // Store byte enables and lane-replicated store data.
    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << addr[1:0];
                st_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                st_be    = addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{wdata[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = wdata;
            end
        endcase
    end

    // Load result formatting from the captured size/sign and offset.
    always_comb begin
        ld_byte = rd_byte[off_q];
        ld_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_fmt = {24'h0, ld_byte};
            3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_fmt = {16'h0, ld_half};
            default: ld_fmt = bus_rdata;
        endcase
    end

    // Next-state, bus register and stall logic.
    always_comb begin
        state_d       = state_q;
        read_data_d   = read_data_q;
        fault_d       = fault_q;
        fault_cause_d = fault_cause_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_be_d      = bus_be_q;
        bus_wdata_d   = bus_wdata_q;
        cnt_d         = cnt_q;
        funct3_d      = funct3_q;
        off_d         = off_q;
        stall         = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = 16'h0;
                if (is_access) begin
                    stall       = 1'b1;
                    state_d     = BUSY;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_write;
                    bus_addr_d  = {addr[31:2], 2'b00};
                    bus_be_d    = mem_write ? st_be : 4'b1111;
                    bus_wdata_d = mem_write ? st_wdata : 32'h0;
                    funct3_d    = funct3;
                    off_d       = addr[1:0];
                end else if (is_illegal || is_misaligned) begin
                    fault_d = 1'b1;
                    if (!fault_q) begin
                        fault_cause_d = is_illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGNED;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                cnt_d = cnt_q + 16'h1;
                if (bus_ack) begin
                    if (!bus_we_q) begin
                        read_data_d = ld_fmt;
                    end
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                    bus_be_d  = 4'b0000;
                    state_d   = DONE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (!bus_we_q) begin
                        read_data_d = 32'h0;
                    end
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                    bus_be_d  = 4'b0000;
                    state_d   = DONE;
                    fault_d   = 1'b1;
                    if (!fault_q) begin
                        fault_cause_d = CAUSE_TIMEOUT;
                    end
                end
            end
            DONE: begin
                // Retire cycle: the same instruction is still presented, so no
                // request is taken here.
                cnt_d   = 16'h0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            read_data_q   <= 32'h0;
            fault_q       <= 1'b0;
            fault_cause_q <= 2'b00;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= 32'h0;
            bus_be_q      <= 4'b0000;
            bus_wdata_q   <= 32'h0;
            cnt_q         <= 16'h0;
            funct3_q      <= 3'b000;
            off_q         <= 2'b00;
        end else begin
            state_q       <= state_d;
            read_data_q   <= read_data_d;
            fault_q       <= fault_d;
            fault_cause_q <= fault_cause_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_be_q      <= bus_be_d;
            bus_wdata_q   <= bus_wdata_d;
            cnt_q         <= cnt_d;
            funct3_q      <= funct3_d;
            off_q         <= off_d;
        end
    end

    assign read_data   = read_data_q;
    assign fault       = fault_q;
    assign fault_cause = fault_cause_q;
    assign bus_req     = bus_req_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_be      = bus_be_q;
    assign bus_wdata   = bus_wdata_q;

endmodule
